// File: rtl/p2f_pattern_checker.sv
// p2f_pattern_checker
// Sink and integrity checker for the read side of the host-to-FPGA CDC FIFO.
// Every valid 128-bit word is compared against an incrementing counter
// pattern. The block reports word and error counts, and captures the index
// and data of the first mismatch.
//
// Ports
//   sys_clk        : FIFO read clock; all logic runs on this clock
//   rstn           : asynchronous active-low reset
//   start / stop   : 1-cycle control pulses (stop wins when both are high)
//   fifo_empty     : FIFO empty flag
//   fifo_rd_en     : FIFO read enable (standard mode, data one cycle later)
//   fifo_dout      : FIFO read data
//   fifo_valid     : high the cycle after an accepted read
//   busy / halted  : registered decodes of the RUN / HALT states
//   word_cnt       : words checked since start (saturating)
//   err_cnt        : mismatching words since start (saturating)
//   err_seen       : sticky mismatch flag
//   first_err_idx  : word_cnt value at the first mismatch
//   first_err_data : received data of the first mismatch
module p2f_pattern_checker #(
  parameter int DATA_W      = 128,
  parameter int CNT_W       = 32,
  parameter int SEED_FIRST  = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_seen,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic SEED_EN = 1'(SEED_FIRST != 0);
  localparam logic HALT_EN = 1'(STOP_ON_ERR != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic                seeded_q, seeded_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                err_seen_q, err_seen_d;
  logic [CNT_W-1:0]    first_err_idx_q, first_err_idx_d;
  logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;

  logic                start_ok_s;
  logic                seed_now_s;
  logic                mismatch_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // start is only honoured outside RUN, and a simultaneous stop overrides it.
  assign start_ok_s = start & ~stop & (state_q != ST_RUN);
  assign seed_now_s = SEED_EN & ~seeded_q;
  // A word arriving in the same cycle as an accepted start is discarded by the
  // clear, so it can never be flagged.
  assign mismatch_s = fifo_valid & ~start_ok_s & ~seed_now_s & (fifo_dout != exp_q);

  assign fifo_rd_en = (state_q == ST_RUN) & ~fifo_empty & ~stop;

  // Next-state logic for the IDLE/RUN/HALT controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (stop)                       state_d = ST_IDLE;
        else if (mismatch_s && HALT_EN) state_d = ST_HALT;
        else                            state_d = ST_RUN;
      end
      ST_HALT: begin
        if (stop)            state_d = ST_IDLE;
        else if (start_ok_s) state_d = ST_RUN;
        else                 state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  // Pattern check and statistics; runs in every state so in-flight words count.
  always_comb begin
    exp_d            = exp_q;
    seeded_d         = seeded_q;
    word_cnt_d       = word_cnt_q;
    err_cnt_d        = err_cnt_q;
    err_seen_d       = err_seen_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    if (start_ok_s) begin
      exp_d            = '0;
      seeded_d         = 1'b0;
      word_cnt_d       = '0;
      err_cnt_d        = '0;
      err_seen_d       = 1'b0;
      first_err_idx_d  = '0;
      first_err_data_d = '0;
    end else if (fifo_valid) begin
      word_cnt_d = sat_inc(word_cnt_q);
      if (seed_now_s) begin
        exp_d    = fifo_dout + DATA_W'(1);
        seeded_d = 1'b1;
      end else begin
        // Expected value always advances: a dropped word is never resynced.
        exp_d = exp_q + DATA_W'(1);
        if (mismatch_s) begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (!err_seen_q) begin
            first_err_idx_d  = word_cnt_q;
            first_err_data_d = fifo_dout;
            err_seen_d       = 1'b1;
          end else begin
            first_err_idx_d  = first_err_idx_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
    end else begin
      exp_d = exp_q;
    end
  end

  // State and statistics registers.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      exp_q            <= '0;
      seeded_q         <= 1'b0;
      word_cnt_q       <= '0;
      err_cnt_q        <= '0;
      err_seen_q       <= 1'b0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      busy_q           <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      exp_q            <= exp_d;
      seeded_q         <= seeded_d;
      word_cnt_q       <= word_cnt_d;
      err_cnt_q        <= err_cnt_d;
      err_seen_q       <= err_seen_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      busy_q           <= busy_d;
      halted_q         <= halted_d;
    end
  end

  assign busy           = busy_q;
  assign halted         = halted_q;
  assign word_cnt       = word_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_seen       = err_seen_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_p2f_pattern_checker.sv
// Testbench for p2f_pattern_checker.
// Three instances are used: A (seeded, keep checking), B (no seed, keep checking)
// and C (seeded, halt on error). Each instance has its own FIFO model, which is
// a queue that returns data one cycle after an accepted read. Expected error
// statistics come from a reference model. It treats word k as correct when it
// equals seed+k (or k when there is no seed).
module tb_p2f_pattern_checker;
  localparam int DW = 128;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [2:0]    start_s, stop_s, empty_s, valid_s, gap_s, rd_lat;
  logic [DW-1:0] dout_s [3];
  wire  [2:0]    rd_s, busy_s, halted_s, eseen_s;
  wire  [DW-1:0] fdata_s [3];
  wire  [CW-1:0] wcnt_s [3];
  wire  [CW-1:0] ecnt_s [3];
  wire  [CW-1:0] fidx_s [3];

  logic [DW-1:0] fq [3][$];
  int            viol [3];
  bit            gaps_on;
  int            n_checks, n_fail;

  p2f_pattern_checker #(.DATA_W(DW), .CNT_W(CW), .SEED_FIRST(1), .STOP_ON_ERR(0)) u_a (
    .sys_clk(clk), .rstn(rstn), .start(start_s[0]), .stop(stop_s[0]),
    .fifo_empty(empty_s[0]), .fifo_rd_en(rd_s[0]), .fifo_dout(dout_s[0]), .fifo_valid(valid_s[0]),
    .busy(busy_s[0]), .halted(halted_s[0]), .word_cnt(wcnt_s[0]), .err_cnt(ecnt_s[0]),
    .err_seen(eseen_s[0]), .first_err_idx(fidx_s[0]), .first_err_data(fdata_s[0]));

  p2f_pattern_checker #(.DATA_W(DW), .CNT_W(CW), .SEED_FIRST(0), .STOP_ON_ERR(0)) u_b (
    .sys_clk(clk), .rstn(rstn), .start(start_s[1]), .stop(stop_s[1]),
    .fifo_empty(empty_s[1]), .fifo_rd_en(rd_s[1]), .fifo_dout(dout_s[1]), .fifo_valid(valid_s[1]),
    .busy(busy_s[1]), .halted(halted_s[1]), .word_cnt(wcnt_s[1]), .err_cnt(ecnt_s[1]),
    .err_seen(eseen_s[1]), .first_err_idx(fidx_s[1]), .first_err_data(fdata_s[1]));

  p2f_pattern_checker #(.DATA_W(DW), .CNT_W(CW), .SEED_FIRST(1), .STOP_ON_ERR(1)) u_c (
    .sys_clk(clk), .rstn(rstn), .start(start_s[2]), .stop(stop_s[2]),
    .fifo_empty(empty_s[2]), .fifo_rd_en(rd_s[2]), .fifo_dout(dout_s[2]), .fifo_valid(valid_s[2]),
    .busy(busy_s[2]), .halted(halted_s[2]), .word_cnt(wcnt_s[2]), .err_cnt(ecnt_s[2]),
    .err_seen(eseen_s[2]), .first_err_idx(fidx_s[2]), .first_err_data(fdata_s[2]));

  // One clock cycle of the FIFO models. Empty is settled and rd_en is sampled on
  // the falling edge. Data for accepted reads is presented after the rising edge,
  // and the control pulses are cleared at that point.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) empty_s[i] = (fq[i].size() == 0) || gap_s[i];
    #1;
    for (int i = 0; i < 3; i++) begin
      rd_lat[i] = rd_s[i];
      if (rd_s[i] && empty_s[i]) viol[i]++;
    end
    @(posedge clk);
    #1;
    start_s = '0;
    stop_s  = '0;
    for (int i = 0; i < 3; i++) begin
      if (rd_lat[i] && fq[i].size() != 0) begin
        valid_s[i] = 1'b1;
        dout_s[i]  = fq[i].pop_front();
      end else begin
        valid_s[i] = 1'b0;
      end
      gap_s[i] = gaps_on ? ($urandom_range(2) == 0) : 1'b0;
    end
  endtask

  task automatic drain(input int inst, output bit to);
    to = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      cycle();
      if (fq[inst].size() == 0 && valid_s[inst] == 1'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic feed(input int inst, input logic [DW-1:0] w[$]);
    foreach (w[k]) fq[inst].push_back(w[k]);
  endtask

  task automatic pulse_start(input int inst);
    start_s[inst] = 1'b1;
    cycle();
  endtask

  task automatic pulse_stop(input int inst);
    stop_s[inst] = 1'b1;
    cycle();
  endtask

  // Reference: word k must equal w[0]+k (seeded) or k (unseeded), mod 2^DW.
  function automatic void ref_model(input bit seed_first, input logic [DW-1:0] w[$],
                                    output int errs, output int fidx, output logic [DW-1:0] fdata);
    logic [DW-1:0] expv;
    errs = 0; fidx = 0; fdata = '0;
    for (int k = 0; k < w.size(); k++) begin
      if (!(seed_first && k == 0)) begin
        expv = seed_first ? (w[0] + DW'(k)) : DW'(k);
        if (w[k] !== expv) begin
          if (errs == 0) begin fidx = k; fdata = w[k]; end
          errs++;
        end
      end
    end
  endfunction

  task automatic test_reset();
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (busy_s[i] !== 1'b0)   begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy_s[i]); end
      n_checks++; if (halted_s[i] !== 1'b0) begin n_fail++; $display("FAIL reset_halted[%0d] got %b want 0", i, halted_s[i]); end
      n_checks++; if (wcnt_s[i] !== '0)     begin n_fail++; $display("FAIL reset_wcnt[%0d] got %0d want 0", i, wcnt_s[i]); end
      n_checks++; if (ecnt_s[i] !== '0)     begin n_fail++; $display("FAIL reset_ecnt[%0d] got %0d want 0", i, ecnt_s[i]); end
      n_checks++; if (eseen_s[i] !== 1'b0)  begin n_fail++; $display("FAIL reset_eseen[%0d] got %b want 0", i, eseen_s[i]); end
      n_checks++; if (fidx_s[i] !== '0)     begin n_fail++; $display("FAIL reset_fidx[%0d] got %0d want 0", i, fidx_s[i]); end
      n_checks++; if (fdata_s[i] !== '0)    begin n_fail++; $display("FAIL reset_fdata[%0d] got %0h want 0", i, fdata_s[i]); end
      n_checks++; if (rd_s[i] !== 1'b0)     begin n_fail++; $display("FAIL reset_rd[%0d] got %b want 0", i, rd_s[i]); end
    end
    rstn = 1'b1;
    cycle();
  endtask

  task automatic test_stream();
    bit to;
    int v0;
    gaps_on = 1'b1;
    v0 = viol[0];
    pulse_start(0);
    for (int k = 0; k < 1000; k++) fq[0].push_back(DW'(k));
    drain(0, to);
    n_checks++; if (to)                begin n_fail++; $display("FAIL stream_drain got timeout want done"); end
    n_checks++; if (wcnt_s[0] !== 1000) begin n_fail++; $display("FAIL stream_wcnt got %0d want 1000", wcnt_s[0]); end
    n_checks++; if (ecnt_s[0] !== 0)    begin n_fail++; $display("FAIL stream_ecnt got %0d want 0", ecnt_s[0]); end
    n_checks++; if (eseen_s[0] !== 0)   begin n_fail++; $display("FAIL stream_eseen got %b want 0", eseen_s[0]); end
    n_checks++; if (viol[0] != v0)      begin n_fail++; $display("FAIL stream_rd_while_empty got %0d want 0", viol[0] - v0); end
    n_checks++; if (busy_s[0] !== 1'b1) begin n_fail++; $display("FAIL stream_busy got %b want 1", busy_s[0]); end
    pulse_stop(0);
    gaps_on = 1'b0;
    n_checks++; if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL stream_stop_busy got %b want 0", busy_s[0]); end
    n_checks++; if (wcnt_s[0] !== 1000) begin n_fail++; $display("FAIL stream_hold_wcnt got %0d want 1000", wcnt_s[0]); end
  endtask

  task automatic test_seed();
    logic [DW-1:0] w[$];
    logic [DW-1:0] fd;
    int e, fi;
    bit to;
    for (int k = 0; k < 16; k++) w.push_back({16{8'h55}} + DW'(k));
    start_s[0] = 1'b1; start_s[1] = 1'b1;
    cycle();
    feed(0, w); feed(1, w);
    drain(0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL seed_drain_a got timeout want done"); end
    drain(1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL seed_drain_b got timeout want done"); end
    ref_model(1'b1, w, e, fi, fd);
    n_checks++; if (ecnt_s[0] !== e)  begin n_fail++; $display("FAIL seed_a_ecnt got %0d want %0d", ecnt_s[0], e); end
    n_checks++; if (wcnt_s[0] !== 16) begin n_fail++; $display("FAIL seed_a_wcnt got %0d want 16", wcnt_s[0]); end
    ref_model(1'b0, w, e, fi, fd);
    n_checks++; if (ecnt_s[1] !== e)  begin n_fail++; $display("FAIL seed_b_ecnt got %0d want %0d", ecnt_s[1], e); end
    n_checks++; if (fidx_s[1] !== fi) begin n_fail++; $display("FAIL seed_b_fidx got %0d want %0d", fidx_s[1], fi); end
    n_checks++; if (fdata_s[1] !== fd) begin n_fail++; $display("FAIL seed_b_fdata got %0h want %0h", fdata_s[1], fd); end
    n_checks++; if (wcnt_s[1] !== 16) begin n_fail++; $display("FAIL seed_b_wcnt got %0d want 16", wcnt_s[1]); end
    stop_s[0] = 1'b1; stop_s[1] = 1'b1;
    cycle();
  endtask

  task automatic test_corrupt();
    logic [DW-1:0] w[$];
    logic [DW-1:0] fd;
    int e, fi;
    bit to;
    for (int k = 0; k < 10; k++) w.push_back(DW'(k));
    w[5] = 128'hDEAD;
    pulse_start(0);
    feed(0, w);
    drain(0, to);
    ref_model(1'b1, w, e, fi, fd);
    n_checks++; if (to)                begin n_fail++; $display("FAIL corrupt_drain got timeout want done"); end
    n_checks++; if (ecnt_s[0] !== e)   begin n_fail++; $display("FAIL corrupt_ecnt got %0d want %0d", ecnt_s[0], e); end
    n_checks++; if (fidx_s[0] !== fi)  begin n_fail++; $display("FAIL corrupt_fidx got %0d want %0d", fidx_s[0], fi); end
    n_checks++; if (fdata_s[0] !== fd) begin n_fail++; $display("FAIL corrupt_fdata got %0h want %0h", fdata_s[0], fd); end
    n_checks++; if (eseen_s[0] !== 1'b1) begin n_fail++; $display("FAIL corrupt_eseen got %b want 1", eseen_s[0]); end
    pulse_stop(0);
  endtask

  task automatic test_halt();
    logic [DW-1:0] w[$];
    logic [DW-1:0] c[$];
    logic [DW-1:0] fd;
    int e, fi;
    bit to;
    for (int k = 0; k < 10; k++) if (k != 3) w.push_back(DW'(k));
    pulse_start(2);
    // One word at a time, so the mismatching word is the last one fetched.
    for (int k = 0; k < w.size(); k++) begin
      if (halted_s[2]) break;
      fq[2].push_back(w[k]);
      c.push_back(w[k]);
      drain(2, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL halt_drain got timeout want done"); end
      cycle();
    end
    ref_model(1'b1, c, e, fi, fd);
    n_checks++; if (halted_s[2] !== 1'b1) begin n_fail++; $display("FAIL halt_halted got %b want 1", halted_s[2]); end
    n_checks++; if (busy_s[2] !== 1'b0)   begin n_fail++; $display("FAIL halt_busy got %b want 0", busy_s[2]); end
    n_checks++; if (ecnt_s[2] !== e)      begin n_fail++; $display("FAIL halt_ecnt got %0d want %0d", ecnt_s[2], e); end
    n_checks++; if (fidx_s[2] !== fi)     begin n_fail++; $display("FAIL halt_fidx got %0d want %0d", fidx_s[2], fi); end
    n_checks++; if (fdata_s[2] !== fd)    begin n_fail++; $display("FAIL halt_fdata got %0h want %0h", fdata_s[2], fd); end
    n_checks++; if (wcnt_s[2] !== c.size()) begin n_fail++; $display("FAIL halt_wcnt got %0d want %0d", wcnt_s[2], c.size()); end
    fq[2].push_back(DW'(5));
    repeat (3) cycle();
    n_checks++; if (rd_s[2] !== 1'b0)   begin n_fail++; $display("FAIL halt_rd got %b want 0", rd_s[2]); end
    n_checks++; if (fq[2].size() != 1)  begin n_fail++; $display("FAIL halt_fifo_level got %0d want 1", fq[2].size()); end
    fq[2].delete();
    pulse_start(2);
    n_checks++; if (busy_s[2] !== 1'b1)   begin n_fail++; $display("FAIL restart_busy got %b want 1", busy_s[2]); end
    n_checks++; if (halted_s[2] !== 1'b0) begin n_fail++; $display("FAIL restart_halted got %b want 0", halted_s[2]); end
    n_checks++; if (wcnt_s[2] !== 0)      begin n_fail++; $display("FAIL restart_wcnt got %0d want 0", wcnt_s[2]); end
    n_checks++; if (ecnt_s[2] !== 0)      begin n_fail++; $display("FAIL restart_ecnt got %0d want 0", ecnt_s[2]); end
    n_checks++; if (eseen_s[2] !== 1'b0)  begin n_fail++; $display("FAIL restart_eseen got %b want 0", eseen_s[2]); end
    n_checks++; if (fidx_s[2] !== 0)      begin n_fail++; $display("FAIL restart_fidx got %0d want 0", fidx_s[2]); end
    pulse_stop(2);
  endtask

  task automatic test_wrap();
    logic [DW-1:0] w[$];
    logic [DW-1:0] m;
    bit to;
    m = '1;
    w.push_back(m - DW'(1));
    w.push_back(m);
    w.push_back(DW'(0));
    pulse_start(0);
    feed(0, w);
    drain(0, to);
    n_checks++; if (to)               begin n_fail++; $display("FAIL wrap_drain got timeout want done"); end
    n_checks++; if (ecnt_s[0] !== 0)  begin n_fail++; $display("FAIL wrap_ecnt got %0d want 0", ecnt_s[0]); end
    n_checks++; if (wcnt_s[0] !== 3)  begin n_fail++; $display("FAIL wrap_wcnt got %0d want 3", wcnt_s[0]); end
    n_checks++; if (eseen_s[0] !== 0) begin n_fail++; $display("FAIL wrap_eseen got %b want 0", eseen_s[0]); end
    pulse_stop(0);
  endtask

  task automatic test_random();
    logic [DW-1:0] w[$];
    logic [DW-1:0] base, v, x, fd;
    int e, fi, n;
    bit to;
    gaps_on = 1'b1;
    for (int r = 0; r < 4; r++) begin
      w.delete();
      base = {$urandom(), $urandom(), $urandom(), $urandom()};
      n = $urandom_range(80, 40);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(29) != 0) begin
          v = base + DW'(k);
          if ($urandom_range(19) == 0) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (x == '0) x = DW'(1);
            v = v ^ x;
          end
          w.push_back(v);
        end
      end
      pulse_start(0);
      feed(0, w);
      drain(0, to);
      ref_model(1'b1, w, e, fi, fd);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_drain got timeout want done", r); end
      n_checks++; if (wcnt_s[0] !== w.size()) begin n_fail++; $display("FAIL rand%0d_wcnt got %0d want %0d", r, wcnt_s[0], w.size()); end
      n_checks++; if (ecnt_s[0] !== e)   begin n_fail++; $display("FAIL rand%0d_ecnt got %0d want %0d", r, ecnt_s[0], e); end
      n_checks++; if (eseen_s[0] !== (e != 0)) begin n_fail++; $display("FAIL rand%0d_eseen got %b want %b", r, eseen_s[0], e != 0); end
      n_checks++; if (fidx_s[0] !== fi)  begin n_fail++; $display("FAIL rand%0d_fidx got %0d want %0d", r, fidx_s[0], fi); end
      n_checks++; if (fdata_s[0] !== fd) begin n_fail++; $display("FAIL rand%0d_fdata got %0h want %0h", r, fdata_s[0], fd); end
      pulse_stop(0);
    end
    gaps_on = 1'b0;
  endtask

  task automatic test_stop_inflight();
    bit got;
    int left, want;
    gaps_on = 1'b0;
    pulse_start(0);
    for (int k = 0; k < 20; k++) fq[0].push_back(DW'(k));
    repeat (3) cycle();
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (valid_s[0]) begin got = 1'b1; break; end
      cycle();
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL stop_wait_valid got timeout want valid"); end
    // stop lands in the cycle where a word is still in flight
    pulse_stop(0);
    left = fq[0].size();
    want = 20 - left;
    n_checks++; if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b want 0", busy_s[0]); end
    n_checks++; if (wcnt_s[0] !== want) begin n_fail++; $display("FAIL stop_inflight_wcnt got %0d want %0d", wcnt_s[0], want); end
    repeat (3) cycle();
    n_checks++; if (rd_s[0] !== 1'b0)    begin n_fail++; $display("FAIL stop_rd got %b want 0", rd_s[0]); end
    n_checks++; if (fq[0].size() != left) begin n_fail++; $display("FAIL stop_fifo_level got %0d want %0d", fq[0].size(), left); end
    n_checks++; if (wcnt_s[0] !== want)  begin n_fail++; $display("FAIL stop_hold_wcnt got %0d want %0d", wcnt_s[0], want); end
    n_checks++; if (ecnt_s[0] !== 0)     begin n_fail++; $display("FAIL stop_ecnt got %0d want 0", ecnt_s[0]); end
    fq[0].delete();
  endtask

  task automatic test_reset_midrun();
    gaps_on = 1'b1;
    pulse_start(0);
    for (int k = 0; k < 100; k++) fq[0].push_back(DW'(k));
    repeat (20) cycle();
    n_checks++; if (busy_s[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b want 1", busy_s[0]); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++; if (busy_s[0] !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_s[0]); end
    n_checks++; if (halted_s[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_halted got %b want 0", halted_s[0]); end
    n_checks++; if (wcnt_s[0] !== 0)      begin n_fail++; $display("FAIL midrst_wcnt got %0d want 0", wcnt_s[0]); end
    n_checks++; if (ecnt_s[0] !== 0)      begin n_fail++; $display("FAIL midrst_ecnt got %0d want 0", ecnt_s[0]); end
    n_checks++; if (eseen_s[0] !== 1'b0)  begin n_fail++; $display("FAIL midrst_eseen got %b want 0", eseen_s[0]); end
    n_checks++; if (fidx_s[0] !== 0)      begin n_fail++; $display("FAIL midrst_fidx got %0d want 0", fidx_s[0]); end
    n_checks++; if (fdata_s[0] !== 0)     begin n_fail++; $display("FAIL midrst_fdata got %0h want 0", fdata_s[0]); end
    n_checks++; if (rd_s[0] !== 1'b0)     begin n_fail++; $display("FAIL midrst_rd got %b want 0", rd_s[0]); end
    for (int i = 0; i < 3; i++) fq[i].delete();
    valid_s = '0;
    rd_lat  = '0;
    gaps_on = 1'b0;
    repeat (2) cycle();
    rstn = 1'b1;
    cycle();
    n_checks++; if (wcnt_s[0] !== 0) begin n_fail++; $display("FAIL midrst_post_wcnt got %0d want 0", wcnt_s[0]); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    start_s  = '0;
    stop_s   = '0;
    valid_s  = '0;
    empty_s  = '1;
    gap_s    = '0;
    rd_lat   = '0;
    gaps_on  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dout_s[i] = '0;
      viol[i]   = 0;
    end
    test_reset();
    test_stream();
    test_seed();
    test_corrupt();
    test_halt();
    test_wrap();
    test_random();
    test_stop_inflight();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
